mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ADDR_W, 32, address width
  DATA_W, 32, data width
  MAX_WAIT, 4, consecutive data-port wins tolerated while fetch is pending (1..15)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk_i  in  1  single clock, rising edge
  rst_i  in  1  asynchronous, active-high reset
  if_req_i  in  1  fetch read request, held until if_ack_o
  if_addr_i  in  ADDR_W  fetch address, stable while if_req_i
  if_rdata_o  out  DATA_W  fetch read data, valid with if_ack_o
  if_ack_o  out  1  one-cycle fetch completion pulse
  dm_req_i  in  1  data-stage request, held until dm_ack_o
  dm_we_i  in  1  1 = write, 0 = read
  dm_addr_i  in  ADDR_W  data address
  dm_wdata_i  in  DATA_W  write data
  dm_rdata_o  out  DATA_W  data read data, valid with dm_ack_o
  dm_ack_o  out  1  one-cycle data completion pulse
  port_req_o  out  1  shared memory request, held until port_ready_i
  port_we_o  out  1  shared memory write enable
  port_addr_o  out  ADDR_W  shared memory address
  port_wdata_o  out  DATA_W  shared memory write data
  port_rdata_i  in  DATA_W  shared memory read data
  port_ready_i  in  1  shared memory completion, any latency >= 0 cycles after port_req_o
  stall_o  out  1  pipeline freeze request
  owner_o  out  2  00 idle, 01 fetch, 10 data

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, BUSY_IF and BUSY_DM.
REQ-004 In IDLE with a qualifying request, the FSM SHALL grant and, on the next edge, register port_addr_o, port_we_o and port_wdata_o, assert port_req_o, and enter BUSY_x.
REQ-005 A request SHALL qualify only while its own ack_o is low, so no grant follows in the ack cycle.
REQ-006 When both requests qualify, the data requester SHALL win unless the starvation rule (REQ-013) applies.
REQ-007 A fetch grant SHALL force port_we_o = 0 and port_wdata_o = 0.
REQ-008 In BUSY_x with port_ready_i = 1, the arbiter SHALL capture port_rdata_i into x_rdata_o, pulse x_ack_o high for exactly one cycle on the next edge, drop port_req_o on that edge, and return to IDLE.
REQ-009 x_rdata_o SHALL hold its value until the next ack for the same requester; a write ack SHALL leave dm_rdata_o unchanged.
REQ-010 Minimum latency SHALL be: request at edge n, port_req_o high after edge n+1, ready in the same cycle, ack high after edge n+2; every further ready-wait cycle adds 1.
REQ-011 port_ready_i in IDLE SHALL be ignored; port_* outputs SHALL hold their last values while port_req_o = 0.
REQ-012 stall_o SHALL equal (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o), combinationally; owner_o SHALL reflect the current state.

Reset
REQ-014 While rst_i = 1, the block SHALL asynchronously force: state IDLE; port_req_o, port_we_o, if_ack_o, dm_ack_o 0; all address, data and rdata registers 0; owner_o 00; wait counter 0.
REQ-015 Reset during BUSY_x SHALL abandon the transaction with no ack issued; the first grant SHALL be possible on the first edge after rst_i falls.

Configuration
REQ-013 Macro ARB_STARVE_GUARD_EN SHALL select the arbitration policy.
  Defined: a 4-bit counter SHALL increment on each data grant made while if_req_i is pending, saturating at MAX_WAIT; at MAX_WAIT the next contested grant SHALL go to fetch; the counter SHALL clear on any fetch grant or when if_req_i = 0 in IDLE.
  Undefined: strict data priority with no counter logic.

Structure
REQ-016 Package mem_arb_pkg SHALL hold the state enum, the owner_o encodings and the MAX_WAIT default.
REQ-017 The starvation counter SHALL be sub-module mem_arb_wait_cnt, instantiated only under ARB_STARVE_GUARD_EN.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
  - Fetch alone: if_req, addr 0x10, ready immediate -> port_req one cycle, if_ack at edge n+2, if_rdata = port_rdata.
  - Data write: dm_we = 1, addr 0x40, wdata 0xDEADBEEF, ready after 3 cycles -> port_we = 1, dm_ack one pulse at edge n+5, dm_rdata unchanged.
  - Simultaneous requests, guard off -> data served first, fetch next, stall_o high throughout until the fetch ack.
  - Guard on, MAX_WAIT = 2, dm_req held continuously with if_req pending -> sequence DM, DM, IF, DM, then counter at 0.
  - rst_i pulsed mid-BUSY_DM -> port_req_o low immediately, no ack issued, fresh grant after release.
  - Spurious port_ready_i in IDLE -> no ack and no state change.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter: FSM states, owner codes
// and the default starvation limit.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_e;

  localparam logic [1:0] OWN_IDLE = 2'b00;
  localparam logic [1:0] OWN_IF   = 2'b01;
  localparam logic [1:0] OWN_DM   = 2'b10;

  localparam int MAX_WAIT_DEF = 4;

  // Clamp the starvation limit into the range a 4-bit counter can reach.
  function automatic logic [3:0] wait_lim(input int m);
    if (m < 1)  return 4'd1;
    if (m > 15) return 4'd15;
    return 4'(m);
  endfunction

endpackage

// File: rtl/mem_arb_wait_cnt.sv
// Saturating count of data grants made while a fetch was left waiting.
module mem_arb_wait_cnt
  import mem_arb_pkg::*;
#(
  parameter logic [3:0] LIMIT = wait_lim(MAX_WAIT_DEF)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inc_i,
  input  logic       clr_i,
  output logic [3:0] cnt_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                        cnt_o <= 4'd0;
    else if (clr_i)                   cnt_o <= 4'd0;
    else if (inc_i && cnt_o < LIMIT)  cnt_o <= cnt_o + 4'd1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one shared memory port.
// Define ARB_STARVE_GUARD_EN to bound how long data traffic may starve fetch.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              port_req_o,
  output logic              port_we_o,
  output logic [ADDR_W-1:0] port_addr_o,
  output logic [DATA_W-1:0] port_wdata_o,
  input  logic [DATA_W-1:0] port_rdata_i,
  input  logic              port_ready_i,
  output logic              stall_o,
  output logic [1:0]        owner_o
);

  localparam logic [3:0] WAIT_LIM = wait_lim(MAX_WAIT);

  state_e     state_q, state_d;
  logic       if_q, dm_q, arb_ok, grant_if, grant_dm, done, wait_full;
  logic [3:0] wait_cnt;

  assign if_q    = if_req_i & ~if_ack_o;
  assign dm_q    = dm_req_i & ~dm_ack_o;
  assign stall_o = if_q | dm_q;

  // The ack cycle is a turnaround: nothing is granted while either ack is high.
  assign arb_ok    = (state_q == IDLE) & ~(if_ack_o | dm_ack_o);
  assign wait_full = (wait_cnt >= WAIT_LIM);
  assign grant_dm  = arb_ok & dm_q & ~(if_q & wait_full);
  assign grant_if  = arb_ok & if_q & ~grant_dm;
  assign done      = (state_q != IDLE) & port_ready_i;

`ifdef ARB_STARVE_GUARD_EN
  logic wait_inc, wait_clr;
  assign wait_inc = grant_dm & if_req_i;
  assign wait_clr = grant_if | ((state_q == IDLE) & ~if_req_i);

  mem_arb_wait_cnt #(.LIMIT(WAIT_LIM)) u_wait_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (wait_inc),
    .clr_i (wait_clr),
    .cnt_o (wait_cnt)
  );
`else
  assign wait_cnt = 4'd0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    owner_o = OWN_IDLE;
    case (state_q)
      IDLE: begin
        if (grant_dm)      state_d = BUSY_DM;
        else if (grant_if) state_d = BUSY_IF;
      end
      BUSY_IF: begin
        owner_o = OWN_IF;
        if (port_ready_i) state_d = IDLE;
      end
      BUSY_DM: begin
        owner_o = OWN_DM;
        if (port_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Port fields are only loaded on a grant, so they hold while port_req_o is low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      port_req_o   <= 1'b0;
      port_we_o    <= 1'b0;
      port_addr_o  <= '0;
      port_wdata_o <= '0;
      if_ack_o     <= 1'b0;
      dm_ack_o     <= 1'b0;
      if_rdata_o   <= '0;
      dm_rdata_o   <= '0;
    end else begin
      if_ack_o <= 1'b0;
      dm_ack_o <= 1'b0;
      if (grant_dm) begin
        port_req_o   <= 1'b1;
        port_we_o    <= dm_we_i;
        port_addr_o  <= dm_addr_i;
        port_wdata_o <= dm_wdata_i;
      end else if (grant_if) begin
        port_req_o   <= 1'b1;
        port_we_o    <= 1'b0;
        port_addr_o  <= if_addr_i;
        port_wdata_o <= '0;
      end else if (done) begin
        port_req_o <= 1'b0;
        if (state_q == BUSY_IF) begin
          if_ack_o   <= 1'b1;
          if_rdata_o <= port_rdata_i;
        end else begin
          dm_ack_o <= 1'b1;
          if (!port_we_o) dm_rdata_o <= port_rdata_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus directed corner
// sequences, with a port monitor scoring grants and acks against queued expectations.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i, dm_req_i, dm_we_i, port_ready_i;
  logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, port_rdata_i;
  logic [31:0] if_rdata_o, dm_rdata_o, port_addr_o, port_wdata_o;
  logic        if_ack_o, dm_ack_o, port_req_o, port_we_o, stall_o;
  logic [1:0]  owner_o;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
    .port_req_o(port_req_o), .port_we_o(port_we_o), .port_addr_o(port_addr_o),
    .port_wdata_o(port_wdata_o), .port_rdata_i(port_rdata_i), .port_ready_i(port_ready_i),
    .stall_o(stall_o), .owner_o(owner_o)
  );

  typedef struct {
    logic        dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
  } txn_t;

  txn_t        vecs[6];
  txn_t        if_exp_q[$], dm_exp_q[$];
  int          n_chk = 0, n_fail = 0;
  logic [31:0] dm_last, if_last;
  int          mem_lat, mem_cnt;
  bit          mem_en;
  logic        mon_prev;
  int          mon_cyc;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory model: ready mem_lat cycles after port_req_o rises.
  initial begin
    port_ready_i = 1'b0;
    port_rdata_i = '0;
    mem_cnt      = 0;
    forever begin
      @(posedge clk_i); #1;
      if (mem_en) begin
        if (!port_req_o || port_ready_i) begin
          port_ready_i = 1'b0;
          mem_cnt      = 0;
        end else if (mem_cnt >= mem_lat) begin
          port_ready_i = 1'b1;
          port_rdata_i = mem_fn(port_addr_o);
        end else begin
          mem_cnt++;
        end
      end
    end
  end

  // Port monitor: grant fields and ack data against queued expectations.
  initial begin
    txn_t        e;
    logic [31:0] exp_rd;
    mon_prev = 1'b0;
    mon_cyc  = 0;
    forever begin
      @(posedge clk_i); #1;
      if (rst_i) begin
        mon_prev = 1'b0;
      end else begin
        if (port_req_o && !mon_prev) begin
          mon_cyc = 1;
          if (owner_o == OWN_DM && dm_exp_q.size() > 0) begin
            e = dm_exp_q[0];
            chk("dm_port_we",    64'(port_we_o),    64'(e.we));
            chk("dm_port_addr",  64'(port_addr_o),  64'(e.addr));
            chk("dm_port_wdata", 64'(port_wdata_o), 64'(e.wdata));
          end else if (owner_o == OWN_IF && if_exp_q.size() > 0) begin
            e = if_exp_q[0];
            chk("if_port_we",    64'(port_we_o),    64'd0);
            chk("if_port_addr",  64'(port_addr_o),  64'(e.addr));
            chk("if_port_wdata", 64'(port_wdata_o), 64'd0);
          end else begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_grant: owner %0d with no queued request", owner_o);
          end
        end else if (port_req_o) begin
          mon_cyc++;
        end
        if (if_ack_o) begin
          if (if_exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_if_ack: rdata %0h", if_rdata_o);
          end else begin
            e       = if_exp_q.pop_front();
            if_last = mem_fn(e.addr);
            chk("if_rdata",      64'(if_rdata_o), 64'(if_last));
            chk("if_req_cycles", 64'(mon_cyc),    64'(e.lat + 1));
          end
        end
        if (dm_ack_o) begin
          if (dm_exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_dm_ack: rdata %0h", dm_rdata_o);
          end else begin
            e       = dm_exp_q.pop_front();
            exp_rd  = e.we ? dm_last : mem_fn(e.addr);
            dm_last = exp_rd;
            chk("dm_rdata",      64'(dm_rdata_o), 64'(exp_rd));
            chk("dm_req_cycles", 64'(mon_cyc),    64'(e.lat + 1));
          end
        end
        mon_prev = port_req_o;
      end
    end
  end

  task automatic run_txn(input txn_t t);
    int cyc;
    bit got;
    mem_lat = t.lat;
    if (t.dm) begin
      dm_exp_q.push_back(t);
      dm_req_i = 1'b1; dm_we_i = t.we; dm_addr_i = t.addr; dm_wdata_i = t.wdata;
    end else begin
      if_exp_q.push_back(t);
      if_req_i = 1'b1; if_addr_i = t.addr;
    end
    #1 chk("stall_on_req", 64'(stall_o), 64'd1);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 20) begin
      @(posedge clk_i); #1;
      cyc++;
      if (cyc == 1) chk("grant_owner", 64'(owner_o), 64'(t.dm ? OWN_DM : OWN_IF));
      got = t.dm ? dm_ack_o : if_ack_o;
    end
    chk("ack_latency", got ? 64'(cyc) : 64'hFFFF, 64'(t.lat + 2));
    if_req_i = 1'b0;
    dm_req_i = 1'b0;
    @(posedge clk_i); #1;
    chk("ack_one_pulse", 64'({if_ack_o, dm_ack_o}), 64'd0);
  endtask

  initial begin
    int          dm_ack_cyc, if_ack_cyc, ng, nda;
    logic        pr;
    logic [7:0]  seq;
    txn_t        t;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         1};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0040, 32'hDEADBEEF,  3};
    vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         2};
    vecs[4] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0,         0};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         0};

    rst_i = 1'b1;
    if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0;
    if_addr_i = '0; dm_addr_i = '0; dm_wdata_i = '0;
    mem_en = 1'b1; mem_lat = 0; dm_last = '0; if_last = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ctrl", 64'({port_req_o, port_we_o, if_ack_o, dm_ack_o, owner_o, stall_o}), 64'd0);
    chk("rst_port_addr",  64'(port_addr_o),  64'd0);
    chk("rst_port_wdata", 64'(port_wdata_o), 64'd0);
    chk("rst_rdata",      64'({if_rdata_o, dm_rdata_o}), 64'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    foreach (vecs[i]) run_txn(vecs[i]);

    // Simultaneous requests: data first, fetch after the turnaround cycle.
    mem_lat = 0;
    dm_exp_q.push_back('{1'b1, 1'b0, 32'h80, 32'h0, 0});
    if_exp_q.push_back('{1'b0, 1'b0, 32'h84, 32'h0, 0});
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h80;
    if_req_i = 1'b1; if_addr_i = 32'h84;
    dm_ack_cyc = 0; if_ack_cyc = 0;
    for (int c = 1; c <= 20 && if_ack_cyc == 0; c++) begin
      @(posedge clk_i); #1;
      if (!if_ack_o) chk("sim_stall_high", 64'(stall_o), 64'd1);
      if (dm_ack_o) begin dm_ack_cyc = c; dm_req_i = 1'b0; end
      if (if_ack_o) begin if_ack_cyc = c; if_req_i = 1'b0; end
    end
    chk("sim_dm_ack_cycle", 64'(dm_ack_cyc), 64'd2);
    chk("sim_if_ack_cycle", 64'(if_ack_cyc), 64'd5);
    if_req_i = 1'b0; dm_req_i = 1'b0;
    @(posedge clk_i); #1;

`ifdef ARB_STARVE_GUARD_EN
    // Data held continuously against a pending fetch, limit of 2.
    mem_lat = 0;
    repeat (3) dm_exp_q.push_back('{1'b1, 1'b0, 32'h200, 32'h0, 0});
    if_exp_q.push_back('{1'b0, 1'b0, 32'h300, 32'h0, 0});
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h200;
    if_req_i = 1'b1; if_addr_i = 32'h300;
    ng = 0; nda = 0; pr = 1'b0; seq = '0;
    for (int c = 0; c < 40 && nda < 3; c++) begin
      @(posedge clk_i); #1;
      if (port_req_o && !pr) begin seq = {seq[5:0], owner_o}; ng++; end
      pr = port_req_o;
      if (if_ack_o) if_req_i = 1'b0;
      if (dm_ack_o) nda++;
    end
    dm_req_i = 1'b0;
    chk("guard_grant_count", 64'(ng), 64'd4);
    chk("guard_sequence",    64'(seq), 64'({OWN_DM, OWN_DM, OWN_IF, OWN_DM}));
    @(posedge clk_i); #1;
    chk("guard_cnt_zero", 64'(dut.wait_cnt), 64'd0);
`endif

    // Reset in the middle of a data read.
    mem_lat = 6;
    t = '{1'b1, 1'b0, 32'h100, 32'h0, 6};
    dm_exp_q.push_back(t);
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h100;
    @(posedge clk_i); #1;
    chk("pre_rst_busy", 64'({port_req_o, owner_o}), 64'({1'b1, OWN_DM}));
    @(posedge clk_i); #3;
    rst_i = 1'b1;
    #1;
    chk("rst_async_ctrl", 64'({port_req_o, owner_o}), 64'd0);
    chk("rst_async_rdata", 64'({if_rdata_o, dm_rdata_o}), 64'd0);
    dm_exp_q.delete();
    dm_last = '0; if_last = '0;
    @(posedge clk_i); #1;
    chk("rst_no_ack", 64'({if_ack_o, dm_ack_o, port_req_o}), 64'd0);
    rst_i = 1'b0;
    mem_lat = 0;
    t.lat = 0;
    dm_exp_q.push_back(t);
    @(posedge clk_i); #1;
    chk("regrant_first_edge", 64'({port_req_o, owner_o}), 64'({1'b1, OWN_DM}));
    @(posedge clk_i); #1;
    chk("regrant_ack", 64'(dm_ack_o), 64'd1);
    dm_req_i = 1'b0;
    @(posedge clk_i); #1;

    // Stray ready with no transaction in flight.
    mem_en = 1'b0;
    port_ready_i = 1'b1;
    port_rdata_i = 32'hBAD0_BAD0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_i); #1;
      chk("spurious_ready_idle", 64'({port_req_o, if_ack_o, dm_ack_o, owner_o}), 64'd0);
    end
    chk("spurious_rdata_hold", 64'({if_rdata_o, dm_rdata_o}), 64'({if_last, dm_last}));
    port_ready_i = 1'b0;
    mem_en = 1'b1;
    @(posedge clk_i); #1;

    chk("if_queue_drained", 64'(if_exp_q.size()), 64'd0);
    chk("dm_queue_drained", 64'(dm_exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
